// File: rtl/io_map_pkg.sv
// Address map and shared types for the memory-mapped I/O block.
package io_map_pkg;

    localparam logic [7:0] IO_LED     = 8'd0;
    localparam logic [7:0] IO_SW      = 8'd1;
    localparam logic [7:0] IO_SEG     = 8'd2;
    localparam logic [7:0] IO_SEG_RDY = 8'd3;
    localparam logic [7:0] IO_IN_STAT = 8'd4;
    localparam logic [7:0] IO_IN_DATA = 8'd5;
    localparam logic [7:0] IO_CNT_WR  = 8'd6;
    localparam logic [7:0] IO_CNT     = 8'd7;
    localparam logic [7:0] IO_BTN     = 8'd8;
    localparam logic [7:0] IO_PRESS   = 8'd9;
    localparam logic [7:0] IO_ID      = 8'd10;

    // Input mailbox status as it appears at IO_IN_STAT bits [1:0].
    typedef struct packed {
        logic ovf;
        logic vld;
    } in_stat_t;

endpackage

// File: rtl/io_edge_sync.sv
// Button synchroniser with rise-pulse output; IO_DEBOUNCE_EN adds a
// stability filter between the 2-FF synchroniser and the edge detector.
module io_edge_sync #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn,
    output logic btn_sync,
    output logic btn_rise
);

    logic meta_r;
    logic sync_r;
    logic prev_r;
    logic level_s;

    // Two-stage synchroniser for the asynchronous button pin.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= btn;
            sync_r <= meta_r;
        end
    end

`ifdef IO_DEBOUNCE_EN
    logic        raw_prev_r;
    logic        stable_r;
    logic [19:0] stable_cnt_r;

    // Accept a new level only after it has been steady for DEBOUNCE_CYCLES.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            raw_prev_r   <= 1'b0;
            stable_r     <= 1'b0;
            stable_cnt_r <= 20'd0;
        end else begin
            raw_prev_r <= sync_r;
            if (sync_r != raw_prev_r) begin
                stable_cnt_r <= 20'd0;
            end else if (sync_r != stable_r) begin
                if (stable_cnt_r >= (DEBOUNCE_CYCLES - 20'd1)) begin
                    stable_r     <= sync_r;
                    stable_cnt_r <= 20'd0;
                end else begin
                    stable_cnt_r <= stable_cnt_r + 20'd1;
                end
            end else begin
                stable_cnt_r <= 20'd0;
            end
        end
    end

    assign level_s = stable_r;
`else
    logic unused_cfg_s;

    assign unused_cfg_s = ^DEBOUNCE_CYCLES;
    assign level_s      = sync_r;
`endif

    // Previous level for one-cycle rise detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= level_s;
        end
    end

    assign btn_sync = level_s;
    assign btn_rise = level_s & ~prev_r;

endmodule

// File: rtl/io_bus_ctrl.sv
// Memory-mapped I/O block: LEDs, switches, button mailbox, seven-seg mailbox,
// cycle and press counters. Define IO_DEBOUNCE_EN to debounce the button.
module io_bus_ctrl
    import io_map_pkg::*;
#(
    parameter int          SW_W            = 16,
    parameter logic [31:0] CNT_INIT        = 32'd0,
    parameter logic [31:0] ID_VALUE        = 32'h0000_C0D1,
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [7:0]      io_addr,
    input  logic [31:0]     io_dout,
    input  logic            io_we,
    input  logic            io_rd,
    output logic [31:0]     io_din,
    input  logic [SW_W-1:0] sw,
    input  logic            btn,
    output logic [SW_W-1:0] led,
    output logic [31:0]     seg_data,
    output logic            seg_vld,
    input  logic            seg_rdy
);

    logic [SW_W-1:0] sw_meta_r;
    logic [SW_W-1:0] sw_sync_r;
    logic            btn_sync_s;
    logic            btn_rise_s;

    logic            wr_led_s;
    logic            wr_seg_s;
    logic            wr_cnt_s;
    logic            rd5_req_s;
    logic            rd5_last_r;
    logic            rd5_pulse_s;

    logic [SW_W-1:0] led_r;
    logic [31:0]     seg_data_r;
    logic            seg_vld_r;
    logic [SW_W-1:0] in_data_r;
    in_stat_t        in_stat_r;
    logic [31:0]     cyc_cnt_r;
    logic [15:0]     press_cnt_r;
    logic [31:0]     rd_data_s;

    io_edge_sync #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_sync (
        .clk      (clk),
        .rstn     (rstn),
        .btn      (btn),
        .btn_sync (btn_sync_s),
        .btn_rise (btn_rise_s)
    );

    // Two-stage synchroniser for the switch bus.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sw_meta_r <= {SW_W{1'b0}};
            sw_sync_r <= {SW_W{1'b0}};
        end else begin
            sw_meta_r <= sw;
            sw_sync_r <= sw_meta_r;
        end
    end

    // Store and load strobe decode.
    always_comb begin
        wr_led_s  = 1'b0;
        wr_seg_s  = 1'b0;
        wr_cnt_s  = 1'b0;
        rd5_req_s = io_rd && (io_addr == IO_IN_DATA);
        if (io_we) begin
            wr_led_s = (io_addr == IO_LED);
            wr_seg_s = (io_addr == IO_SEG);
            wr_cnt_s = (io_addr == IO_CNT_WR);
        end else begin
            wr_led_s = 1'b0;
            wr_seg_s = 1'b0;
            wr_cnt_s = 1'b0;
        end
    end

    // A load held on IO_IN_DATA for several cycles clears the mailbox once.
    assign rd5_pulse_s = rd5_req_s && !rd5_last_r;

    // Load-strobe history for clear-on-read qualification.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd5_last_r <= 1'b0;
        end else begin
            rd5_last_r <= rd5_req_s;
        end
    end

    // LED register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            led_r <= {SW_W{1'b0}};
        end else if (wr_led_s) begin
            led_r <= io_dout[SW_W-1:0];
        end
    end

    // Seven-seg output mailbox; a store beats a same-cycle acceptance.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            seg_data_r <= 32'd0;
            seg_vld_r  <= 1'b0;
        end else if (wr_seg_s) begin
            seg_data_r <= io_dout;
            seg_vld_r  <= 1'b1;
        end else if (seg_vld_r && seg_rdy) begin
            seg_vld_r  <= 1'b0;
        end
    end

    // Button mailbox; a new capture beats a same-cycle clear-on-read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_data_r   <= {SW_W{1'b0}};
            in_stat_r   <= '{ovf: 1'b0, vld: 1'b0};
            press_cnt_r <= 16'd0;
        end else if (btn_rise_s) begin
            press_cnt_r <= press_cnt_r + 16'd1;
            if (!in_stat_r.vld || rd5_pulse_s) begin
                in_data_r     <= sw_sync_r;
                in_stat_r.vld <= 1'b1;
                in_stat_r.ovf <= 1'b0;
            end else begin
                in_stat_r.ovf <= 1'b1;
            end
        end else if (rd5_pulse_s) begin
            in_stat_r.vld <= 1'b0;
            in_stat_r.ovf <= 1'b0;
        end
    end

    // Free-running cycle counter with CPU load.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc_cnt_r <= CNT_INIT;
        end else if (wr_cnt_s) begin
            cyc_cnt_r <= io_dout;
        end else begin
            cyc_cnt_r <= cyc_cnt_r + 32'd1;
        end
    end

    // Combinational load-data mux, independent of io_rd.
    always_comb begin
        rd_data_s = 32'd0;
        case (io_addr)
            IO_SW:      rd_data_s[SW_W-1:0] = sw_sync_r;
            IO_SEG_RDY: rd_data_s = {31'd0, ~seg_vld_r};
            IO_IN_STAT: rd_data_s = {30'd0, in_stat_r};
            IO_IN_DATA: rd_data_s[SW_W-1:0] = in_data_r;
            IO_CNT:     rd_data_s = cyc_cnt_r;
            IO_BTN:     rd_data_s = {31'd0, btn_sync_s};
            IO_PRESS:   rd_data_s = {16'd0, press_cnt_r};
            IO_ID:      rd_data_s = ID_VALUE;
            default:    rd_data_s = 32'd0;
        endcase
    end

    assign io_din   = rd_data_s;
    assign led      = led_r;
    assign seg_data = seg_data_r;
    assign seg_vld  = seg_vld_r;

endmodule
